// File: rtl/car_mode_input.sv
// Switch front-end for the car-light controller: synchronises and debounces the
// two slide-switch lines, emits a commit strobe and counts rejected bounces.
module car_mode_input #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BOUNCE_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          switch_raw,
    output logic [1:0]          mode,
    output logic                mode_change,
    output logic                mode_stable,
    output logic [BOUNCE_W-1:0] bounce_cnt
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DEBOUNCE_TICKS - 1);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [1:0]          sync1_q, sync2_q;
    logic [PW-1:0]       pre_q, pre_d;
    logic [0:0]          state_q, state_d;
    logic [1:0]          cand_q, cand_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [1:0]          mode_q, mode_d;
    logic                chg_q, chg_d;
    logic                stable_q, stable_d;
    logic [BOUNCE_W-1:0] bounce_q, bounce_d;
    logic                tick;
    logic                bounce_inc;

    // Free-running prescaler; switch activity never restarts it.
    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        hold_d     = hold_q;
        mode_d     = mode_q;
        chg_d      = 1'b0;
        bounce_inc = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != mode_q) begin
                    cand_d  = sync2_q;
                    hold_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                // Input changes take priority over a coincident tick, which is then lost.
                if (sync2_q == mode_q) begin
                    state_d    = ST_STABLE;
                    bounce_inc = 1'b1;
                end else if (sync2_q != cand_q) begin
                    cand_d     = sync2_q;
                    hold_d     = '0;
                    bounce_inc = 1'b1;
                end else if (tick && hold_q == HOLD_LAST) begin
                    mode_d  = cand_q;
                    chg_d   = 1'b1;
                    state_d = ST_STABLE;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
        stable_d = (state_d == ST_STABLE);
        bounce_d = (bounce_inc && bounce_q != '1) ? bounce_q + 1'b1 : bounce_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            pre_q    <= '0;
            state_q  <= ST_STABLE;
            cand_q   <= 2'b00;
            hold_q   <= '0;
            mode_q   <= 2'b00;
            chg_q    <= 1'b0;
            stable_q <= 1'b1;
            bounce_q <= '0;
        end else begin
            sync1_q  <= switch_raw;
            sync2_q  <= sync1_q;
            pre_q    <= pre_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            hold_q   <= hold_d;
            mode_q   <= mode_d;
            chg_q    <= chg_d;
            stable_q <= stable_d;
            bounce_q <= bounce_d;
        end
    end

    assign mode        = mode_q;
    assign mode_change = chg_q;
    assign mode_stable = stable_q;
    assign bounce_cnt  = bounce_q;

endmodule

// File: tb/tb_car_mode_input.sv
// Directed bench for car_mode_input with TICK_DIV=4, DEBOUNCE_TICKS=3.
module tb_car_mode_input;

    logic       clk;
    logic       rst;
    logic [1:0] switch_raw;
    logic [1:0] mode;
    logic       mode_change;
    logic       mode_stable;
    logic [7:0] bounce_cnt;

    int checks;
    int errors;

    // Cumulative monitor counters; tasks compare against snapshots.
    int chg_total;
    int bad_chg_total;
    int seen01_total;

    car_mode_input #(
        .TICK_DIV(4),
        .DEBOUNCE_TICKS(3),
        .BOUNCE_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch_raw(switch_raw),
        .mode(mode),
        .mode_change(mode_change),
        .mode_stable(mode_stable),
        .bounce_cnt(bounce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        chg_total     = 0;
        bad_chg_total = 0;
        seen01_total  = 0;
    end

    always @(posedge clk) begin
        logic [1:0] prev;
        prev = mode;
        #1;
        if (mode_change) begin
            chg_total = chg_total + 1;
            if (mode == prev) bad_chg_total = bad_chg_total + 1;
        end
        if (mode == 2'b01) seen01_total = seen01_total + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        switch_raw = 2'b00;
        cycles(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        do_reset();
        c0 = chg_total;
        checks++;
        if (mode !== 2'b00 || mode_stable !== 1'b1 || mode_change !== 1'b0 || bounce_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: mode=%b stable=%b chg=%b bounce=%0d, want 00 1 0 0",
                     mode, mode_stable, mode_change, bounce_cnt);
        end
        cycles(20);
        checks++;
        if (mode !== 2'b00 || mode_stable !== 1'b1 || bounce_cnt !== 8'd0 || chg_total != c0) begin
            errors++;
            $display("FAIL idle_00: mode=%b stable=%b bounce=%0d pulses=%0d, want 00 1 0 0",
                     mode, mode_stable, bounce_cnt, chg_total - c0);
        end
    endtask

    task automatic test_clean_change();
        int c0, b0, first;
        do_reset();
        c0 = chg_total;
        b0 = bad_chg_total;
        first = -1;
        switch_raw = 2'b10;
        cycles(2);
        checks++;
        if (mode_stable !== 1'b1) begin
            errors++;
            $display("FAIL stable_before_sync: mode_stable=%b, want 1", mode_stable);
        end
        cycles(1);
        checks++;
        if (mode_stable !== 1'b0) begin
            errors++;
            $display("FAIL stable_fall_3: mode_stable=%b, want 0", mode_stable);
        end
        for (int n = 4; n <= 20; n++) begin
            cycles(1);
            if (first < 0 && mode == 2'b10) first = n;
        end
        checks++;
        if (first < 11 || first > 15) begin
            errors++;
            $display("FAIL clean_latency: commit after %0d cycles, want 11..15", first);
        end
        checks++;
        if (mode !== 2'b10 || mode_stable !== 1'b1 || bounce_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clean_final: mode=%b stable=%b bounce=%0d, want 10 1 0",
                     mode, mode_stable, bounce_cnt);
        end
        checks++;
        if (chg_total - c0 != 1 || bad_chg_total != b0) begin
            errors++;
            $display("FAIL clean_pulse: pulses=%0d bad=%0d, want 1 0",
                     chg_total - c0, bad_chg_total - b0);
        end
    endtask

    task automatic test_bounce_abort();
        int c0;
        do_reset();
        c0 = chg_total;
        switch_raw = 2'b01;
        cycles(5);
        switch_raw = 2'b00;
        cycles(10);
        checks++;
        if (mode !== 2'b00 || bounce_cnt !== 8'd1 || mode_stable !== 1'b1 || chg_total != c0) begin
            errors++;
            $display("FAIL bounce_abort: mode=%b bounce=%0d stable=%b pulses=%0d, want 00 1 1 0",
                     mode, bounce_cnt, mode_stable, chg_total - c0);
        end
    endtask

    task automatic test_candidate_restart();
        int c0, s0;
        do_reset();
        c0 = chg_total;
        s0 = seen01_total;
        switch_raw = 2'b01;
        cycles(8);
        switch_raw = 2'b11;
        cycles(10);
        checks++;
        if (mode !== 2'b00) begin
            errors++;
            $display("FAIL restart_early: mode=%b at 10 cycles after 11 edge, want 00", mode);
        end
        cycles(8);
        checks++;
        if (mode !== 2'b11 || bounce_cnt !== 8'd1) begin
            errors++;
            $display("FAIL restart_commit: mode=%b bounce=%0d, want 11 1", mode, bounce_cnt);
        end
        checks++;
        if (chg_total - c0 != 1 || seen01_total != s0) begin
            errors++;
            $display("FAIL restart_pulse: pulses=%0d mode01_cycles=%0d, want 1 0",
                     chg_total - c0, seen01_total - s0);
        end
    endtask

    task automatic test_bounce_saturate();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            switch_raw = 2'b01;
            cycles(4);
            switch_raw = 2'b00;
            cycles(4);
        end
        checks++;
        if (bounce_cnt !== 8'd200) begin
            errors++;
            $display("FAIL bounce_200: bounce_cnt=%0d, want 200", bounce_cnt);
        end
        for (int i = 0; i < 100; i++) begin
            switch_raw = 2'b01;
            cycles(4);
            switch_raw = 2'b00;
            cycles(4);
        end
        checks++;
        if (bounce_cnt !== 8'd255 || mode !== 2'b00) begin
            errors++;
            $display("FAIL bounce_sat: bounce_cnt=%0d mode=%b, want 255 00", bounce_cnt, mode);
        end
    endtask

    task automatic test_reset_mid_settle();
        int c0, first;
        do_reset();
        switch_raw = 2'b11;
        cycles(6);
        checks++;
        if (mode_stable !== 1'b0) begin
            errors++;
            $display("FAIL mid_settle_entry: mode_stable=%b, want 0", mode_stable);
        end
        c0 = chg_total;
        rst = 1'b1;
        #1;
        checks++;
        if (mode !== 2'b00 || mode_stable !== 1'b1 || mode_change !== 1'b0 || bounce_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_values: mode=%b stable=%b chg=%b bounce=%0d, want 00 1 0 0",
                     mode, mode_stable, mode_change, bounce_cnt);
        end
        cycles(3);
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 20; n++) begin
            cycles(1);
            if (n == 10) begin
                checks++;
                if (mode !== 2'b00) begin
                    errors++;
                    $display("FAIL post_reset_early: mode=%b 10 cycles after release, want 00", mode);
                end
            end
            if (first < 0 && mode == 2'b11) first = n;
        end
        checks++;
        if (first < 11 || first > 15 || mode !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_commit: first=%0d mode=%b, want 11..15 and 11", first, mode);
        end
        checks++;
        if (chg_total - c0 != 1) begin
            errors++;
            $display("FAIL post_reset_pulses: pulses=%0d, want 1", chg_total - c0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        switch_raw = 2'b00;
        test_reset();
        test_clean_change();
        test_bounce_abort();
        test_candidate_restart();
        test_bounce_saturate();
        test_reset_mid_settle();
        checks++;
        if (bad_chg_total != 0) begin
            errors++;
            $display("FAIL change_without_mode: count=%0d, want 0", bad_chg_total);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
